mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arb_pick.sv | 41 ++++
 rtl/mem_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam logic [2:0]  FUNCT3_LB  = 3'b000;
    localparam logic [2:0]  FUNCT3_LH  = 3'b001;
    localparam logic [2:0]  FUNCT3_LW  = 3'b010;
    localparam logic [2:0]  FUNCT3_LBU = 3'b100;
    localparam logic [2:0]  FUNCT3_LHU = 3'b101;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FFF4;

    // Stores return nothing, so only a granted load or fetch owns the next-cycle read data.
    function automatic owner_t resp_owner(input logic if_gnt, input logic ls_gnt, input logic ls_we);
        owner_t own;
        if (ls_gnt) begin
            own = ls_we ? OWN_NONE : OWN_LS;
        end else if (if_gnt) begin
            own = OWN_IF;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and load/store; round-robin when MEM_ARBITER_RR_EN is defined.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  owner_t last_winner,
    output logic   if_gnt,
    output logic   ls_gnt
);

`ifndef MEM_ARBITER_RR_EN
    logic unused_last_winner_s;
    assign unused_last_winner_s = |last_winner;
`endif

    // One-hot grant from the current requests and arbitration history.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (if_req && ls_req) begin
`ifdef MEM_ARBITER_RR_EN
            if (last_winner == OWN_LS) begin
                if_gnt = 1'b1;
            end else begin
                ls_gnt = 1'b1;
            end
`else
            ls_gnt = 1'b1;
`endif
        end else if (ls_req) begin
            ls_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end else begin
            if_gnt = 1'b0;
            ls_gnt = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and load/store with 1-cycle read latency.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default is fixed ls-over-if priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [2:0] FETCH_FUNCT3 = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_write_mem,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_read_address,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    owner_t owner_r;
    owner_t last_winner_s;
    logic   if_pick_s;
    logic   ls_pick_s;

`ifdef MEM_ARBITER_RR_EN
    owner_t last_winner_r;

    // Remember who won the most recent grant so the other side wins the next contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_r <= OWN_IF;
        end else if (ls_gnt) begin
            last_winner_r <= OWN_LS;
        end else if (if_gnt) begin
            last_winner_r <= OWN_IF;
        end else begin
            last_winner_r <= last_winner_r;
        end
    end

    assign last_winner_s = last_winner_r;
`else
    assign last_winner_s = OWN_IF;
`endif

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .last_winner (last_winner_s),
        .if_gnt      (if_pick_s),
        .ls_gnt      (ls_pick_s)
    );

    // Grants are suppressed for as long as reset is held.
    always_comb begin
        if_gnt = if_pick_s & ~rst;
        ls_gnt = ls_pick_s & ~rst;
    end

    // Memory request mux: idle bus carries zeros and the fetch funct3.
    always_comb begin
        mem_write_mem     = 1'b0;
        mem_funct3        = FETCH_FUNCT3;
        mem_read_address  = 32'h0000_0000;
        mem_write_address = 32'h0000_0000;
        mem_write_data    = 32'h0000_0000;
        if (ls_gnt) begin
            mem_write_mem     = ls_we;
            mem_funct3        = ls_funct3;
            mem_read_address  = ls_addr;
            mem_write_address = ls_addr;
            mem_write_data    = ls_wdata;
        end else if (if_gnt) begin
            mem_read_address  = if_addr;
            mem_write_address = if_addr;
        end else begin
            mem_write_mem     = 1'b0;
        end
    end

    // Response owner for the data returned one cycle after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= resp_owner(if_gnt, ls_gnt, ls_we);
        end
    end

    // Route read data to the owner only.
    always_comb begin
        if_rvalid = (owner_r == OWN_IF);
        ls_rvalid = (owner_r == OWN_LS);
        if_rdata  = if_rvalid ? mem_read_data : 32'h0000_0000;
        ls_rdata  = ls_rvalid ? mem_read_data : 32'h0000_0000;
    end

endmodule
